// File: rtl/pipe_stage_chain_if.sv
// rtl/pipe_stage_chain_if.sv - stream, stall/flush and observation bundle for pipe_stage_chain
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) ();

    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic [DEPTH-1:0]         stall;
    logic [DEPTH-1:0]         flush;
    logic [DEPTH-1:0]         stage_valid;
    logic [DEPTH*WIDTH-1:0]   stage_data;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         bubble_cnt;

    modport master (
        output in_valid,
        output in_data,
        output stall,
        output flush,
        input  in_ready,
        input  stage_valid,
        input  stage_data,
        input  out_valid,
        input  out_data,
        input  stall_cnt,
        input  bubble_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  stall,
        input  flush,
        output in_ready,
        output stage_valid,
        output stage_data,
        output out_valid,
        output out_data,
        output stall_cnt,
        output bubble_cnt
    );

endinterface

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - DEPTH pipeline registers with valid, stall, flush; optional PIPE_PERF_CNT_EN counters
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_chain_if.slave bus
);

    // A stall anywhere downstream freezes every stage upstream of it.
    logic [DEPTH-1:0] hold;

    // What each stage would load if it advanced: the previous stage, or the input for stage 0.
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] up_hold;
    logic [WIDTH-1:0] up_data [DEPTH];

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        assign hold[g] = |bus.stall[DEPTH-1:g];

        if (g == 0) begin : g_head
            assign up_valid[g] = bus.in_valid;
            assign up_data[g]  = bus.in_data;
            assign up_hold[g]  = 1'b0;
        end else begin : g_body
            assign up_valid[g] = valid_q[g-1];
            assign up_data[g]  = data_q[g-1];
            assign up_hold[g]  = hold[g-1];
        end

        assign bus.stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    // Per-stage next state: flush beats hold, hold beats load, frozen upstream inserts a bubble.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            if (bus.flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (up_hold[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else begin
                valid_d[i] = up_valid[i];
                data_d[i]  = up_data[i];
            end
        end
    end

    // Stage registers; reset clears both valid and payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready    = ~hold[0];
    assign bus.stage_valid = valid_q;
    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.out_data    = data_q[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
    localparam int BW = $clog2(DEPTH + 1);

    // A stage counts as a new bubble when flushed or when its upstream neighbour is frozen.
    logic [DEPTH-1:0] bubble;
    logic [BW-1:0]    bubble_n;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W:0]   stall_sum;
    logic [CNT_W:0]   bubble_sum;

    assign bubble = bus.flush | (~hold & up_hold);

    // Number of bubbles created on this edge.
    always_comb begin
        bubble_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bubble_n = bubble_n + BW'(bubble[i]);
        end
    end

    assign stall_sum  = {1'b0, stall_q} + (CNT_W+1)'(1);
    assign bubble_sum = {1'b0, bubble_q} + (CNT_W+1)'(bubble_n);

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (hold[0]) begin
                stall_q <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
            end
            bubble_q <= bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
        end
    end

    assign bus.stall_cnt  = stall_q;
    assign bus.bubble_cnt = bubble_q;
`else
    assign bus.stall_cnt  = '0;
    assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain
module tb_pipe_stage_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [WIDTH-1:0] sb [$];
    int k_next;
    int k_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] sdat(input int i);
        return bus.stage_data[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [CNT_W-1:0] cexp(input int v);
        return PERF ? CNT_W'(v) : '0;
    endfunction

    // Monitor: an entry leaves the last stage on an edge without stall, flush or reset.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !bus.stall[DEPTH-1] && !bus.flush[DEPTH-1]) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: actual=%0h required=none", bus.out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                chk("out_data", bus.out_data, e);
            end
        end
    end

    task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                         input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.stall    = st;
        bus.flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int ncyc, input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        for (int c = 0; c < ncyc; c++) begin
            logic acc;
            drive(k_next <= k_last, WIDTH'(k_next), st, fl);
            acc = bus.in_ready;
            tick();
            if (acc && k_next <= k_last) k_next++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, '0, '0);
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        drive(1'b0, '0, '0, '0);
        for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
        chk({name, "_drain"}, sb.size(), 0);
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic push_range(input int a, input int b);
        for (int v = a; v <= b; v++) sb.push_back(WIDTH'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Test 1: reset state, latency DEPTH, ordered output
        do_reset();
        chk("rst_stage_valid", bus.stage_valid, 0);
        chk("rst_stage_data", bus.stage_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        chk("rst_bubble_cnt", bus.bubble_cnt, 0);
        push_range(1, 5);
        k_next = 1; k_last = 5;
        run(3, '0, '0);
        chk("t1_early_valid", bus.out_valid, 0);
        run(1, '0, '0);
        chk("t1_first_valid", bus.out_valid, 1);
        chk("t1_first_data", bus.out_data, 1);
        run(6, '0, '0);
        drain("t1");

        // Test 2: stall[1] for 2 cycles while stage1 holds 3
        do_reset();
        push_range(1, 8);
        k_next = 1; k_last = 8;
        run(4, '0, '0);
        run(1, 4'b0010, '0);
        chk("t2_s0_held", sdat(0), 4);
        chk("t2_s1_held", sdat(1), 3);
        chk("t2_s2_bubble", bus.stage_valid[2], 0);
        chk("t2_s3_data", sdat(3), 2);
        chk("t2_in_ready", bus.in_ready, 0);
        run(1, 4'b0010, '0);
        chk("t2_valid_vec", bus.stage_valid, 4'b0011);
        chk("t2_s0_still", sdat(0), 4);
        run(12, '0, '0);
        drain("t2");
        chk("t2_stall_cnt", bus.stall_cnt, cexp(2));
        chk("t2_bubble_cnt", bus.bubble_cnt, cexp(2));

        // Test 3: flush[0] and flush[1] together on a full pipe (4 and 5 are lost)
        do_reset();
        sb.push_back(1); sb.push_back(2); sb.push_back(3);
        push_range(6, 8);
        k_next = 1; k_last = 8;
        run(4, '0, '0);
        run(1, '0, 4'b0011);
        chk("t3_front_bubbles", bus.stage_valid[1:0], 0);
        chk("t3_s2_valid", bus.stage_valid[2], 1);
        chk("t3_s2_data", sdat(2), 3);
        chk("t3_s3_data", sdat(3), 2);
        run(12, '0, '0);
        drain("t3");
        chk("t3_stall_cnt", bus.stall_cnt, cexp(0));
        chk("t3_bubble_cnt", bus.bubble_cnt, cexp(2));

        // Test 4: flush[2] with stall[2], stall[2] held two more cycles (2 is lost)
        do_reset();
        sb.push_back(1);
        push_range(3, 8);
        k_next = 1; k_last = 8;
        run(4, '0, '0);
        run(1, 4'b0100, 4'b0100);
        chk("t4_s2_valid", bus.stage_valid[2], 0);
        chk("t4_s2_data", sdat(2), 0);
        chk("t4_in_ready", bus.in_ready, 0);
        chk("t4_s1_held", sdat(1), 3);
        chk("t4_s0_held", sdat(0), 4);
        run(2, 4'b0100, '0);
        chk("t4_valid_vec", bus.stage_valid, 4'b0011);
        chk("t4_s2_still0", sdat(2), 0);
        run(12, '0, '0);
        drain("t4");
        chk("t4_stall_cnt", bus.stall_cnt, cexp(3));
        chk("t4_bubble_cnt", bus.bubble_cnt, cexp(4));

        // Test 5: stall[3] for 3 cycles with all stages valid
        do_reset();
        push_range(1, 8);
        k_next = 1; k_last = 8;
        run(4, '0, '0);
        for (int c = 0; c < 3; c++) begin
            run(1, 4'b1000, '0);
            chk("t5_out_data", bus.out_data, 1);
            chk("t5_in_ready", bus.in_ready, 0);
            chk("t5_all_valid", bus.stage_valid, 4'b1111);
        end
        chk("t5_stall_cnt", bus.stall_cnt, cexp(3));
        chk("t5_bubble_cnt", bus.bubble_cnt, cexp(0));
        run(12, '0, '0);
        drain("t5");
        chk("t5_bubble_end", bus.bubble_cnt, cexp(0));

        // Test 6: reset mid-stream while stall[2] is asserted
        do_reset();
        sb.push_back(1);
        push_range(32'h11, 32'h14);
        k_next = 1; k_last = 4;
        run(4, '0, '0);
        run(1, 4'b0100, '0);
        rst = 1'b1;
        run(1, 4'b0100, '0);
        rst = 1'b0;
        chk("t6_stage_valid", bus.stage_valid, 0);
        chk("t6_stage_data", bus.stage_data, 0);
        chk("t6_out_valid", bus.out_valid, 0);
        chk("t6_stall_cnt", bus.stall_cnt, 0);
        chk("t6_bubble_cnt", bus.bubble_cnt, 0);
        k_next = 32'h11; k_last = 32'h14;
        run(3, '0, '0);
        chk("t6_early_valid", bus.out_valid, 0);
        run(1, '0, '0);
        chk("t6_first_valid", bus.out_valid, 1);
        chk("t6_first_data", bus.out_data, 32'h11);
        run(8, '0, '0);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
